// File: rtl/ysyx_24080006_mdu_pkg.sv
// Shared execute-stage types for the RV32M multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mdu_op_e, mdu_set_t (decoder control word), mdu_state_e, MDU_ITER.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    MULL = 2'd0,
    MULH = 2'd1,
    DIV  = 2'd2,
    REM  = 2'd3
  } mdu_op_e;

  typedef struct packed {
    logic    mdu_enable;
    logic    signed_a;
    logic    signed_b;
    mdu_op_e mdu_op;
  } mdu_set_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Number of radix-2 steps for one 32-bit multiply or divide.
  localparam int unsigned MDU_ITER = 32;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_if.sv
// Request/response bundle between execute stage and the MDU.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on request, out_valid/out_ready on result.
// Signals: in_valid, in_ready, mdu_set, rs1, rs2, flush, out_valid, out_ready, result.
// master = issuing stage side, slave = MDU side.
interface ysyx_24080006_mdu_if;
  import ysyx_24080006_pkg::*;

  logic        in_valid;
  logic        in_ready;
  mdu_set_t    mdu_set;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, mdu_set, rs1, rs2, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mdu_set, rs1, rs2, flush, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/ysyx_24080006_mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: hi_i/lo_i current partial state, opnd_i multiplicand or divisor,
//        is_div_i selects divide, hi_o/lo_o next partial state.
module ysyx_24080006_mdu_step (
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] opnd_i,
  input  logic        is_div_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // One shared 34-bit adder. Multiply adds {c,hi} = hi + mcand (bit 32 is
  // the carry). Divide subtracts the divisor from {hi,lo[31]}; the extra top
  // bit is the borrow, i.e. the sign of the trial.
  logic [33:0] add_a;
  logic [33:0] add_b;
  logic [33:0] sum;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (is_div_i) begin
      add_a = {1'b0, hi_i, lo_i[31]};
      add_b = ~{2'b00, opnd_i};
    end else begin
      add_a = {2'b00, hi_i};
      add_b = lo_i[0] ? {2'b00, opnd_i} : 34'd0;
    end
    sum = add_a + add_b + {33'd0, is_div_i};
  end

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      if (!sum[33]) begin
        hi_o = sum[31:0];
        lo_o = {lo_i[30:0], 1'b1};
      end else begin
        hi_o = {hi_i[30:0], lo_i[31]};
        lo_o = {lo_i[30:0], 1'b0};
      end
    end else begin
      // {c,hi,lo} >>= 1
      hi_o = sum[32:1];
      lo_o = {sum[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/ysyx_24080006_mdu.sv
// RV32M iterative multiply/divide unit (MULL/MULH/DIV/REM, signed or unsigned).
// Latency: 34 cycles accept->out_valid (1 for divide-by-zero, 1 for multiply
//          when YSYX_MDU_FAST_MUL_EN is defined).
// Backpressure: in_ready only when idle; result held in DONE until out_ready.
// Ports: clock, rst_n (async active-low), bus (ysyx_24080006_mdu_if.slave).
// Optional macro: YSYX_MDU_FAST_MUL_EN -- single-cycle 33x33 multiply path.
module ysyx_24080006_mdu
  import ysyx_24080006_pkg::*;
(
  input  logic                      clock,
  input  logic                      rst_n,
  ysyx_24080006_mdu_if.slave        bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opnd_q, opnd_d;
  mdu_op_e     op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] res_q, res_d;

  logic        idle;
  logic        accept;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign idle          = (state_q == ST_IDLE);
  assign bus.in_ready  = idle;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;

  // flush beats a same-cycle request
  assign accept = bus.in_valid && idle && bus.mdu_set.mdu_enable && !bus.flush;

  assign neg_a = bus.mdu_set.signed_a & bus.rs1[31];
  assign neg_b = bus.mdu_set.signed_b & bus.rs2[31];
  assign mag_a = neg_a ? (~bus.rs1 + 32'd1) : bus.rs1;
  assign mag_b = neg_b ? (~bus.rs2 + 32'd1) : bus.rs2;

  ysyx_24080006_mdu_step u_step (
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_op(op_q)),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign restoration on the magnitude results.
  assign prod_fix = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
  assign quo_fix  = neg_q ? (~lo_q + 32'd1) : lo_q;
  assign rem_fix  = neg_q ? (~hi_q + 32'd1) : hi_q;

`ifdef YSYX_MDU_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  assign fast_prod = $signed({neg_a, bus.rs1}) * $signed({neg_b, bus.rs2});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = bus.mdu_set.mdu_op;
          // remainder takes the dividend's sign, everything else the XOR
          neg_d  = (bus.mdu_set.mdu_op == REM) ? neg_a : (neg_a ^ neg_b);
          hi_d   = '0;
          lo_d   = mag_a;
          opnd_d = mag_b;
          cnt_d  = 6'(MDU_ITER);
          if (is_div_op(bus.mdu_set.mdu_op) && (bus.rs2 == 32'd0)) begin
            res_d   = (bus.mdu_set.mdu_op == DIV) ? 32'hFFFF_FFFF : bus.rs1;
            state_d = ST_DONE;
          end
`ifdef YSYX_MDU_FAST_MUL_EN
          else if (!is_div_op(bus.mdu_set.mdu_op)) begin
            {hi_d, lo_d} = fast_prod[63:0];
            res_d   = (bus.mdu_set.mdu_op == MULH) ? fast_prod[63:32] : fast_prod[31:0];
            state_d = ST_DONE;
          end
`endif
          else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        case (op_q)
          MULL:    res_d = prod_fix[31:0];
          MULH:    res_d = prod_fix[63:32];
          DIV:     res_d = quo_fix;
          default: res_d = rem_fix;
        endcase
        state_d = ST_DONE;
      end

      default: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (bus.flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= MULL;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: doc/ysyx_24080006_mdu.md
# ysyx_24080006_mdu

Iterative multiply/divide unit for the RV32M extension, sitting in the execute stage beside the ALU. It consumes the decoded `mdu_set_t` control word and the two register operands, and runs a radix-2 shift-add multiply or restoring divide over 32 cycles. It returns one 32-bit result to writeback through a valid/ready handshake.

## Interface
- No parameters; iteration count is the package constant `MDU_ITER` (32).
- `clock`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit idle, can accept a request
- `mdu_set`  in  `mdu_set_t`  enable, `signed_a`, `signed_b`, `mdu_op` (MULL/MULH/DIV/REM)
- `rs1`, `rs2`  in  32  operands a, b
- `flush`  in  1  abandon the in-flight operation
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `result`  out  32  result

## Operation
- Accept: `in_valid && in_ready && mdu_set.mdu_enable`; latch the op, the sign flags and the operand magnitudes. A negative operand is one whose `signed_x` is set and whose bit 31 is 1; its magnitude is its two's-complement negation.
- `neg_res` rule:
  - MULL/MULH and DIV: sign(a) XOR sign(b).
  - REM: sign(a).
- States:
  - `IDLE` → `CALC` on accept.
  - `IDLE` → `DONE` on accept when the op is DIV/REM and rs2 == 0 (divide-by-zero fast path).
  - `CALC` runs 32 steps → `FIX`.
  - `FIX` → `DONE`.
  - `DONE` → `IDLE` on `out_valid && out_ready`.
- Multiply step: if `lo[0]`, do a 33-bit add `{c,hi} = hi + mcand`; then `{c,hi,lo} >>= 1`. After 32 steps, `{hi,lo}` holds the 64-bit unsigned product.
- Divide step: `trial = {hi,lo[31]} - divisor` (33 bits).
  - If trial ≥ 0: `hi = trial[31:0]`, `lo = {lo[30:0],1}`.
  - Else: `hi = {hi[30:0],lo[31]}`, `lo = {lo[30:0],0}`.
  - After 32 steps, quotient = `lo`, remainder = `hi`.
- `FIX`: negate the 64-bit product, or the quotient (DIV) or remainder (REM), when `neg_res`. Then select:
  - MULL → `lo`.
  - MULH → `hi`.
  - DIV → quotient.
  - REM → remainder.
- Divide by zero: DIV → 0xFFFFFFFF; REM → rs1 unchanged.
- Overflow 0x80000000 / -1 (signed): the magnitude path already gives quotient 0x80000000 and remainder 0. No special case is needed.
- `flush`: any state → `IDLE` next edge, `out_valid` drops. `flush` wins over a same-cycle `in_valid`, which is not accepted.
- `in_valid` with `mdu_enable` = 0 is ignored.

## Timing
- Reset values: state `IDLE`, `in_ready` = 1, `out_valid` = 0, `result` = 0, counter = 0, all datapath registers 0.
- `in_ready` = (state == `IDLE`), combinational from state.
- Latency from the accept edge:
  - Iterative path: `out_valid` high 34 cycles later (32 CALC + FIX + DONE entry).
  - Divide by zero: 1 cycle.
- `result` is registered and held stable while `out_valid && !out_ready`.
- No accept is possible in the cycle of result handoff; the earliest new accept is the cycle after `DONE` → `IDLE`.
- Counter: 6 bits, loaded with 32 on accept, decremented each CALC cycle; `CALC` exits when it reaches 1.
- Reset asserted mid-operation: immediate return to reset values, no partial result is emitted.

## Configuration
- `YSYX_MDU_FAST_MUL_EN` defined:
  - MULL/MULH use a single-cycle 33×33 signed combinational multiply on sign-extended operands, registered into `{hi,lo}`.
  - The path is `IDLE` → `DONE`; `out_valid` arrives 1 cycle after accept.
  - The divide path is unchanged.
- Undefined: every op uses the iterative path above, and no `*` operator is instantiated.

## Structure
- Shared package `ysyx_24080006_pkg` holds:
  - `mdu_op_e` and `mdu_set_t`, already shared.
  - New `mdu_state_e` {IDLE, CALC, FIX, DONE}.
  - Constant `MDU_ITER = 32`.
- One sub-module is natural: `ysyx_24080006_mdu_step`. It is a combinational 33-bit add/sub step that takes `hi`, `lo`, the operand and the op, and returns the next `hi`/`lo`. The FSM, counter and sign fix stay in the top.

## Test plan
- MULL, signed both: 7 × -3 → 0xFFFFFFEB; `out_valid` 34 cycles after accept (1 cycle with the macro).
- MULH signed 0x80000000 × 0x80000000 → 0x40000000; MULH unsigned 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV signed -7 / 2 → 0xFFFFFFFD; REM signed -7 / 2 → 0xFFFFFFFF; DIV unsigned 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with `out_valid` 1 cycle after accept. Signed 0x80000000 / -1 → DIV 0x80000000, REM 0.
- Backpressure: `out_ready` held low 5 cycles → `result` and `out_valid` stable; `in_ready` rises the cycle after the handshake.
- Flush on the 10th CALC cycle with `in_valid` also high → `in_ready` = 1 next cycle, no `out_valid`, the new request is not accepted.
